// File: rtl/spkid_decoder_if.sv
// Event readout channel of the spike-ID decoder: the master offers {frame_id, group}
// words with ev_valid and the slave accepts them with ev_ready.
interface spkid_decoder_if;
    logic [15:0] ev_data;
    logic        ev_valid;
    logic        ev_ready;

    modport master (
        output ev_data,
        output ev_valid,
        input  ev_ready
    );

    modport slave (
        input  ev_data,
        input  ev_valid,
        output ev_ready
    );
endinterface

// File: rtl/spkid_decoder.sv
// Receives the motoneuron spike-ID stream in the rawclk domain: samples on neuron_clk rises,
// de-duplicates words, counts spikes per frame and queues events for the host.
module spkid_decoder #(
    parameter int NN      = 8,
    parameter int FIFO_AW = 5
) (
    input  logic              rawclk,
    input  logic              reset_sim_n,
    input  logic              neuron_clk,
    input  logic [15:0]       spkid_in,
    input  logic              clear,
    spkid_decoder_if.master   ev,
    output logic [15:0]       frame_count,
    output logic              frame_done,
    output logic [15:0]       malformed_cnt,
    output logic [15:0]       drop_cnt,
    output logic              overflow
);

    localparam int G      = NN - 1;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int CW     = FIFO_AW + 1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage p0..p2: neuron_clk synchroniser and edge flop
    logic nclk_p0, nclk_p1, nclk_p2;
    logic cap;

    always_ff @(posedge rawclk or negedge reset_sim_n) begin
        if (!reset_sim_n) begin
            nclk_p0 <= 1'b0;
            nclk_p1 <= 1'b0;
            nclk_p2 <= 1'b0;
        end else begin
            nclk_p0 <= neuron_clk;
            nclk_p1 <= nclk_p0;
            nclk_p2 <= nclk_p1;
        end
    end

    assign cap = nclk_p1 & ~nclk_p2;

    // Capture stage: the word settled on the previous neuron_clk fall
    logic [15:0] word_p0;
    logic        vld_p0;

    always_ff @(posedge rawclk or negedge reset_sim_n) begin
        if (!reset_sim_n) begin
            word_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= cap & ~clear;
            if (cap) begin
                word_p0 <= spkid_in;
            end
        end
    end

    // Decode stage: classify the captured word against the last valid one
    logic [G-1:0]      grp;
    logic              spk;
    logic              malformed;
    logic              good;
    logic              fire;
    logic              bound;
    logic [G-1:0]      prev_grp;
    logic              prev_spk;
    logic [8:0]        frame_id;
    logic [8:0]        frame_id_nxt;
    logic [15:0]       run_cnt;
    logic [DATA_W-1:0] entry;

    assign grp          = word_p0[8+G-1:8];
    assign spk          = word_p0[7];
    assign malformed    = word_p0[15] | (|word_p0[6:0]);
    assign good         = vld_p0 & ~malformed & ~clear;
    assign fire         = good & spk & (~prev_spk | (grp != prev_grp));
    assign bound        = good & (grp < prev_grp);
    assign frame_id_nxt = bound ? frame_id + 9'd1 : frame_id;
    // The boundary word already belongs to the new frame, so it is tagged with the new id.
    assign entry        = {frame_id_nxt, 7'(grp)};

    // FIFO: storage array plus a registered head that drives ev_data/ev_valid
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      mem_cnt;
    logic [CW-1:0]      occ;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic               refill;

    assign pop    = ev.ev_valid & ev.ev_ready;
    assign occ    = mem_cnt + CW'(ev.ev_valid);
    assign full   = (occ == CW'(DEPTH));
    assign push   = fire & (~full | pop);
    assign drop   = fire & full & ~pop;
    assign refill = (~ev.ev_valid | pop) & (mem_cnt != '0);

    always_ff @(posedge rawclk) begin
        if (push) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge rawclk or negedge reset_sim_n) begin
        if (!reset_sim_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            ev.ev_valid <= 1'b0;
            ev.ev_data  <= '0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            ev.ev_valid <= 1'b0;
            ev.ev_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (refill) begin
                rd_ptr      <= rd_ptr + 1'b1;
                ev.ev_data  <= mem[rd_ptr];
                ev.ev_valid <= 1'b1;
            end else if (pop) begin
                ev.ev_valid <= 1'b0;
            end
            mem_cnt <= mem_cnt + CW'(push) - CW'(refill);
        end
    end

    // Frame bookkeeping and statistics, updated on the push edge
    always_ff @(posedge rawclk or negedge reset_sim_n) begin
        if (!reset_sim_n) begin
            prev_grp      <= '0;
            prev_spk      <= 1'b0;
            frame_id      <= '0;
            run_cnt       <= '0;
            frame_count   <= '0;
            frame_done    <= 1'b0;
            malformed_cnt <= '0;
            drop_cnt      <= '0;
            overflow      <= 1'b0;
        end else if (clear) begin
            prev_grp      <= '0;
            prev_spk      <= 1'b0;
            frame_id      <= '0;
            run_cnt       <= '0;
            frame_count   <= '0;
            frame_done    <= 1'b0;
            malformed_cnt <= '0;
            drop_cnt      <= '0;
            overflow      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (vld_p0 && malformed) begin
                malformed_cnt <= sat_inc(malformed_cnt);
            end
            if (good) begin
                prev_grp <= grp;
                prev_spk <= spk;
            end
            if (bound) begin
                frame_count <= run_cnt;
                frame_done  <= 1'b1;
                frame_id    <= frame_id_nxt;
                run_cnt     <= fire ? 16'd1 : 16'd0;
            end else if (fire) begin
                run_cnt <= sat_inc(run_cnt);
            end
            // A dropped event still counts towards the frame total.
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spkid_decoder.sv
// Bench for spkid_decoder: word-level reference model with an event queue, driven by
// directed scenarios and a randomized word stream with random consumer backpressure.
module tb_spkid_decoder;

    logic        rawclk = 1'b0;
    logic        reset_sim_n;
    logic        neuron_clk;
    logic [15:0] spkid_in;
    logic        clear;
    logic [15:0] frame_count;
    logic        frame_done;
    logic [15:0] malformed_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    spkid_decoder_if ev_if ();

    spkid_decoder #(.NN(8), .FIFO_AW(5)) dut (
        .rawclk        (rawclk),
        .reset_sim_n   (reset_sim_n),
        .neuron_clk    (neuron_clk),
        .spkid_in      (spkid_in),
        .clear         (clear),
        .ev            (ev_if),
        .frame_count   (frame_count),
        .frame_done    (frame_done),
        .malformed_cnt (malformed_cnt),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow)
    );

    always #5 rawclk = ~rawclk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops   = 0;
    logic [15:0] last_pop = '0;
    bit          rnd_rdy  = 1'b0;

    // Reference model state
    int          m_mal, m_drop, m_run, m_fid, m_pgrp, m_fc;
    bit          m_pspk, m_ovf;
    logic [15:0] m_q [$];
    int          exp_fc [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_mal = 0; m_drop = 0; m_run = 0; m_fid = 0; m_pgrp = 0; m_fc = 0;
        m_pspk = 1'b0; m_ovf = 1'b0;
        m_q.delete();
        exp_fc.delete();
    endtask

    task automatic model_word(input logic [15:0] w, input bit pop_with);
        int g;
        bit s, fire_m, bnd;
        g = int'(w[14:8]);
        s = w[7];
        if (w[15] || w[6:0] != 7'd0) begin
            m_mal = sat16(m_mal + 1);
            return;
        end
        fire_m = s && (!m_pspk || g != m_pgrp);
        bnd    = g < m_pgrp;
        if (bnd) begin
            exp_fc.push_back(m_run);
            m_fc  = m_run;
            m_fid = (m_fid + 1) % 512;
            m_run = fire_m ? 1 : 0;
        end else if (fire_m) begin
            m_run = sat16(m_run + 1);
        end
        if (fire_m) begin
            if (m_q.size() >= 32 && !pop_with) begin
                m_drop = sat16(m_drop + 1);
                m_ovf  = 1'b1;
            end else begin
                m_q.push_back(16'(m_fid * 128 + g));
            end
        end
        m_pgrp = g;
        m_pspk = s;
    endtask

    task automatic tick();
        @(negedge rawclk);
        if (rnd_rdy) ev_if.ev_ready = 1'($urandom_range(0, 1));
    endtask

    // One neuron_clk period: word changes with the fall, sampled after the rise.
    task automatic send_word(input logic [15:0] w, input bit pop_with);
        neuron_clk = 1'b0;
        spkid_in   = w;
        repeat (4) tick();
        neuron_clk = 1'b1;
        model_word(w, pop_with);
        if (pop_with) begin
            repeat (3) tick();
            ev_if.ev_ready = 1'b1;
            tick();
            ev_if.ev_ready = 1'b0;
        end else begin
            repeat (4) tick();
        end
    endtask

    function automatic logic [15:0] mkword(input int g, input bit s);
        return {1'b0, 7'(g), s, 7'b0};
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        model_reset();
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && (m_q.size() != 0 || ev_if.ev_valid); i++) tick();
        check_val("drain_left", 32'(m_q.size()) + 32'(ev_if.ev_valid), 0);
    endtask

    // Scoreboard: pops, held data under backpressure, frame_done values
    initial begin : monitor
        bit          hold_pend;
        logic [15:0] hold_data;
        hold_pend = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge rawclk);
            #1;
            if (!reset_sim_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend)
                    check_val("hold", {15'b0, ev_if.ev_valid, ev_if.ev_data}, {16'h0001, hold_data});
                hold_pend = ev_if.ev_valid && !ev_if.ev_ready && !clear;
                hold_data = ev_if.ev_data;
                if (frame_done) begin
                    check_val("fd_expected", 32'(exp_fc.size() != 0), 1);
                    if (exp_fc.size() != 0) check_val("frame_count", frame_count, exp_fc.pop_front());
                end
                if (ev_if.ev_valid && ev_if.ev_ready && !clear) begin
                    n_pops++;
                    last_pop = ev_if.ev_data;
                    check_val("pop_expected", 32'(m_q.size() != 0), 1);
                    if (m_q.size() != 0) check_val("ev_data", ev_if.ev_data, m_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat, p0, g;
        logic [15:0] w, last_w;
        reset_sim_n    = 1'b0;
        neuron_clk     = 1'b0;
        spkid_in       = '0;
        clear          = 1'b0;
        ev_if.ev_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge rawclk);
        #1;
        check_val("rst_valid", ev_if.ev_valid, 0);
        check_val("rst_data", ev_if.ev_data, 0);
        check_val("rst_fc", frame_count, 0);
        check_val("rst_fd", frame_done, 0);
        check_val("rst_mal", malformed_cnt, 0);
        check_val("rst_drop", drop_cnt, 0);
        check_val("rst_ovf", overflow, 0);
        @(negedge rawclk);
        reset_sim_n = 1'b1;

        // Single spike with latency measurement on the second rise
        p0 = n_pops;
        send_word(16'h0000, 1'b0);
        neuron_clk = 1'b0;
        spkid_in   = 16'h0380;
        repeat (4) tick();
        neuron_clk = 1'b1;
        model_word(16'h0380, 1'b0);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge rawclk);
            #1;
            if (ev_if.ev_valid) begin
                lat = n;
                break;
            end
        end
        check_val("latency", lat, 5);
        check_val("ss_data", ev_if.ev_data, 16'h0003);
        @(negedge rawclk);
        send_word(16'h0380, 1'b0);
        send_word(16'h0400, 1'b0);
        ev_if.ev_ready = 1'b1;
        wait_drain();
        check_val("ss_events", n_pops - p0, 1);

        // Frame wrap: sweep with spikes on groups 5 and 90
        do_clear();
        for (int i = 0; i < 128; i++) send_word(mkword(i, (i == 5 || i == 90)), 1'b0);
        send_word(16'h0000, 1'b0);
        check_val("wrap_fc", frame_count, 2);
        send_word(16'h0180, 1'b0);
        wait_drain();
        check_val("wrap_fid", last_pop, 16'h0081);

        // Malformed words leave prev_grp at 1
        p0 = n_pops;
        send_word(16'h8380, 1'b0);
        send_word(16'h0381, 1'b0);
        check_val("mal_cnt", malformed_cnt, 2);
        send_word(16'h0280, 1'b0);
        wait_drain();
        check_val("mal_prev", frame_count, 2);
        check_val("mal_events", n_pops - p0, 1);

        // Backpressure: 40 events into a 32-deep FIFO
        do_clear();
        ev_if.ev_ready = 1'b0;
        for (int i = 1; i <= 40; i++) send_word(mkword(i, 1'b1), 1'b0);
        check_val("bp_drop", drop_cnt, 8);
        check_val("bp_ovf", overflow, 1);
        p0 = n_pops;
        rnd_rdy = 1'b1;
        wait_drain();
        rnd_rdy = 1'b0;
        check_val("bp_stored", n_pops - p0, 32);

        // Full FIFO with a pop on the push edge
        do_clear();
        ev_if.ev_ready = 1'b0;
        for (int i = 1; i <= 32; i++) send_word(mkword(i, 1'b1), 1'b0);
        check_val("full_nodrop", drop_cnt, 0);
        send_word(mkword(33, 1'b1), 1'b1);
        check_val("simul_drop", drop_cnt, 0);
        check_val("simul_ovf", overflow, 0);
        p0 = n_pops;
        ev_if.ev_ready = 1'b1;
        wait_drain();
        check_val("simul_occ", n_pops - p0, 32);

        // Clear with a nonempty FIFO and nonzero counters
        ev_if.ev_ready = 1'b0;
        send_word(16'h8000, 1'b0);
        send_word(16'h0280, 1'b0);
        send_word(16'h0380, 1'b0);
        check_val("pre_clr_fc", frame_count, 33);
        do_clear();
        #1;
        check_val("clr_valid", ev_if.ev_valid, 0);
        check_val("clr_fc", frame_count, 0);
        check_val("clr_mal", malformed_cnt, 0);
        check_val("clr_drop", drop_cnt, 0);
        check_val("clr_ovf", overflow, 0);

        // Randomized word stream with random backpressure
        rnd_rdy = 1'b1;
        g = 0;
        last_w = 16'h0000;
        for (int i = 0; i < 180; i++) begin
            case ($urandom_range(0, 9))
                0: w = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                1: w = mkword($urandom_range(0, 127), 1'($urandom_range(0, 1))) | 16'($urandom_range(1, 127));
                2, 3: w = last_w;
                default: begin
                    g = g + int'($urandom_range(0, 20));
                    if (g > 127) g = int'($urandom_range(0, 10));
                    w = mkword(g, 1'($urandom_range(0, 1)));
                end
            endcase
            send_word(w, 1'b0);
            last_w = w;
        end
        rnd_rdy = 1'b0;
        ev_if.ev_ready = 1'b1;
        wait_drain();
        check_val("rnd_mal", malformed_cnt, m_mal);
        check_val("rnd_drop", drop_cnt, m_drop);
        check_val("rnd_ovf", overflow, m_ovf);
        check_val("rnd_fc", frame_count, m_fc);

        // Reset in mid-frame, then resume with lower groups
        ev_if.ev_ready = 1'b0;
        send_word(mkword(60, 1'b1), 1'b0);
        send_word(mkword(70, 1'b1), 1'b0);
        neuron_clk = 1'b0;
        #3;
        reset_sim_n = 1'b0;
        #1;
        check_val("mrst_valid", ev_if.ev_valid, 0);
        check_val("mrst_data", ev_if.ev_data, 0);
        check_val("mrst_mal", malformed_cnt, 0);
        check_val("mrst_fd", frame_done, 0);
        model_reset();
        tick();
        tick();
        reset_sim_n = 1'b1;
        ev_if.ev_ready = 1'b1;
        send_word(mkword(10, 1'b1), 1'b0);
        send_word(mkword(11, 1'b1), 1'b0);
        wait_drain();
        check_val("mrst_fc", frame_count, 0);
        check_val("mrst_last", last_pop, 16'h000B);

        check_val("fd_missing", 32'(exp_fc.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spkid_decoder.md
# spkid_decoder

Receiving end of the motoneuron spike-ID word stream. Consumes the 16-bit spike-ID words a neuron pool emits (`{1'b0, group[NN-2:0], spike, 7'b0}`, updated on the falling edge of `neuron_clk`) and samples them in the `rawclk` domain. It de-duplicates repeated words, counts spikes per population sweep (frame), and buffers spike events in a FIFO for the host readout path with a valid/ready handshake.

## Interface
- `NN`, default 8: pool size exponent; group field width `G = NN-1` (7 bits at default).
- `FIFO_AW`, default 5: FIFO address width; depth `2^FIFO_AW` (32).
- `rawclk`, in, 1: sole clock.
- `reset_sim_n`, in, 1: reset; one clock, reset asynchronous and active-low.
- `neuron_clk`, in, 1: pool neuron clock, treated as data; synchronised internally.
- `spkid_in`, in, 16: spike-ID word from the pool.
- `clear`, in, 1: synchronous clear of counters, flags and FIFO.
- `ev_data`, out, 16: `{frame_id[8:0], group[6:0]}` of the oldest event (upper group bits zero when `G<7`).
- `ev_valid`, out, 1: `ev_data` holds an event.
- `ev_ready`, in, 1: consumer accepts when `ev_valid & ev_ready`.
- `frame_count`, out, 16: spikes counted in the last completed frame.
- `frame_done`, out, 1: one-cycle pulse when `frame_count` updates.
- `malformed_cnt`, out, 16: saturating count of malformed words.
- `drop_cnt`, out, 16: saturating count of events lost to a full FIFO.
- `overflow`, out, 1: sticky; set on the first drop.

## Operation
- Sampling: 2-flop synchroniser plus an edge flop on `neuron_clk`. A detected rising edge produces `cap`, and `spkid_in` is registered on `cap`. The word is stable because it changed on the preceding falling edge.
- Decode of the captured word `w`:
  - `grp = w[8+G-1:8]`, `spk = w[7]`.
  - The word is malformed if `w[15]` is set or `w[6:0]` is nonzero. A malformed word increments `malformed_cnt` (saturating at 0xFFFF), is otherwise ignored, and does not update the previous-word registers.
- De-duplication: registers `prev_grp` and `prev_spk` hold the last valid word. An event fires when `spk=1` and (`prev_spk=0` or `grp != prev_grp`). Repeats of an identical spiking word fire nothing.
- Frame boundary: a valid word with `grp < prev_grp` (wrap) ends the frame. The boundary word belongs to the new frame.
  - `frame_count` is loaded with the running count.
  - `frame_done` pulses.
  - `frame_id` increments, wrapping mod 512.
  - The running count is set to 1 if the boundary word fires an event, else 0.
- Running count: +1 per event, saturating at 0xFFFF.
- FIFO is first-word-fall-through, depth `2^FIFO_AW`, with the entry formed from the current `frame_id` and `grp`.
  - If the FIFO is full and no pop occurs in the same cycle, the event is dropped: `drop_cnt`+1 (saturating) and `overflow` is set. The running count still increments.
  - Simultaneous push and pop on a full FIFO is accepted with no drop.
- `clear` zeroes:
  - both counters, `frame_count`, running count and `frame_id`;
  - `overflow` and the FIFO pointers;
  - `prev_grp` (to 0) and `prev_spk` (to 0).
  
  When `clear` is asserted, the `cap` of that cycle is discarded.

## Timing
- Reset (async assert, sync release) values:
  - all counters and `frame_id` are 0;
  - `ev_valid`, `frame_done` and `overflow` are 0;
  - `ev_data` is 0;
  - the FIFO is empty;
  - `prev_grp=0`, `prev_spk=0`, and synchroniser flops are 0.
- Latency: a `neuron_clk` rising edge gives `cap` 3 `rawclk` cycles later. The capture register loads at `cap`. Decode and push occur on the next edge. `ev_valid` goes high 1 cycle after the push into an empty FIFO, i.e. 5 `rawclk` edges after the `neuron_clk` rise.
- `frame_done` and `frame_count` update on the same edge as the push of the boundary word.
- Handshake:
  - `ev_data` is stable while `ev_valid & !ev_ready`.
  - The pop occurs on the edge where both are high, and the next entry is visible the following cycle.
  - `ev_ready` is ignored when `ev_valid=0`.
- Constraint: `neuron_clk` high and low phases must each be ≥3 `rawclk` periods. Faster inputs are not supported.
- Reset mid-stream: all state is lost, and the first valid word after release cannot produce a frame boundary because `prev_grp=0`.

## Test plan
- Single spike: words `0x0000`, `0x0380` (grp 3, spk), `0x0380`, `0x0400` over four `neuron_clk` periods -> exactly one event, `ev_data=0x0003`, `ev_valid` 5 rawclk cycles after the second rising edge.
- Frame wrap: sweep grp 0..127 with spikes on grp 5 and 90, then a word with grp 0 and no spike -> `frame_done` pulse, `frame_count=2`, next events carry `frame_id=1`.
- Malformed words: `0x8380` and `0x0381` -> `malformed_cnt=2`, no events, `prev_grp` unchanged.
- Backpressure: `ev_ready=0` while 40 distinct spiking groups arrive -> 32 events stored, `drop_cnt=8`, `overflow=1`. Draining then returns groups in order, with `ev_data` held between pops.
- Full FIFO with simultaneous pop: full FIFO, `ev_ready=1` on the same cycle as a new event -> no drop, occupancy stays 32.
- `clear` and reset: assert `clear` with a nonempty FIFO and nonzero counters -> all zero next cycle. Deassert `reset_sim_n` mid-frame -> outputs are immediately at reset values, and resumption produces no spurious `frame_done`.
